// File: rtl/kb_answer_entry.sv
// Keyboard answer entry for the arithmetic game.
// Turns decoded PS/2 set-2 bytes into a decimal answer (kb_result). Backspace
// is supported. Enter commits the answer with a one-cycle answer_ready pulse
// and locks the entry until new_ques clears and re-arms it. A small prefix
// tracker keeps break (F0) and extended (E0) sequences aligned, so released
// keys never act as presses.
module kb_answer_entry #(
   parameter int MAX_DIGITS = 3,
   parameter int MAX_VALUE  = 127
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       new_ques,
   output logic [6:0] kb_result,
   output logic [1:0] digit_count,
   output logic       answer_ready,
   output logic       locked,
   output logic       reject
);

   localparam logic [7:0] CODE_ENTER = 8'h5A;
   localparam logic [7:0] CODE_BKSP  = 8'h66;
   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BREAK = 2'd1,
      EXT   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [6:0]  result_nx;
   logic [1:0]  count_nx;
   logic        locked_nx;
   logic        ready_nx;
   logic        reject_nx;
   logic        is_make;
   logic        is_ext_enter;
   logic [4:0]  key_digit;
   logic [10:0] appended;
   logic        count_full;
   logic        too_big;

   // Map a scan code to {hit, digit}. Main-row and keypad digits are both
   // accepted.
   function automatic logic [4:0] decode_digit(input logic [7:0] code);
      case (code)
         8'h45, 8'h70: decode_digit = {1'b1, 4'd0};
         8'h16, 8'h69: decode_digit = {1'b1, 4'd1};
         8'h1E, 8'h72: decode_digit = {1'b1, 4'd2};
         8'h26, 8'h7A: decode_digit = {1'b1, 4'd3};
         8'h25, 8'h6B: decode_digit = {1'b1, 4'd4};
         8'h2E, 8'h73: decode_digit = {1'b1, 4'd5};
         8'h36, 8'h74: decode_digit = {1'b1, 4'd6};
         8'h3D, 8'h6C: decode_digit = {1'b1, 4'd7};
         8'h3E, 8'h75: decode_digit = {1'b1, 4'd8};
         8'h46, 8'h7D: decode_digit = {1'b1, 4'd9};
         default:      decode_digit = {1'b0, 4'd0};
      endcase
   endfunction

   assign key_digit = decode_digit(scan_code);
   // The value is computed 11 bits wide, so an overflow past 127 is still
   // visible and can be compared against the limit.
   assign appended   = ({4'd0, kb_result} * 11'd10) + {7'd0, key_digit[3:0]};
   assign count_full = (digit_count == 2'(MAX_DIGITS));
   assign too_big    = (appended > 11'(MAX_VALUE));

   // Next-state logic for the prefix tracker and the answer entry.
   always_comb begin
      state_nx     = state;
      result_nx    = kb_result;
      count_nx     = digit_count;
      locked_nx    = locked;
      ready_nx     = 1'b0;
      reject_nx    = 1'b0;
      is_make      = 1'b0;
      is_ext_enter = 1'b0;
      if (new_ques) begin
         state_nx  = IDLE;
         result_nx = 7'd0;
         count_nx  = 2'd0;
         locked_nx = 1'b0;
      end else if (scan_valid) begin
         case (state)
            IDLE: begin
               if (scan_code == CODE_BREAK) begin
                  state_nx = BREAK;
               end else if (scan_code == CODE_EXT) begin
                  state_nx = EXT;
               end else begin
                  is_make = 1'b1;
               end
            end
            BREAK: begin
               state_nx = IDLE;
            end
            EXT: begin
               if (scan_code == CODE_BREAK) begin
                  state_nx = BREAK;
               end else begin
                  state_nx     = IDLE;
                  is_ext_enter = (scan_code == CODE_ENTER);
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
         // A locked entry ignores key actions, but the prefix tracker above
         // keeps running so that break codes stay aligned.
         if (locked) begin
            locked_nx = 1'b1;
         end else if (is_make && key_digit[4]) begin
            if (count_full || too_big) begin
               reject_nx = 1'b1;
            end else begin
               result_nx = appended[6:0];
               count_nx  = digit_count + 2'd1;
            end
         end else if (is_make && (scan_code == CODE_BKSP)) begin
            if (digit_count != 2'd0) begin
               result_nx = kb_result / 7'd10;
               count_nx  = digit_count - 2'd1;
            end else begin
               count_nx = 2'd0;
            end
         end else if (is_ext_enter || (is_make && (scan_code == CODE_ENTER))) begin
            if (digit_count != 2'd0) begin
               ready_nx  = 1'b1;
               locked_nx = 1'b1;
            end else begin
               locked_nx = 1'b0;
            end
         end else begin
            locked_nx = locked;
         end
      end else begin
         state_nx = state;
      end
   end

   // Register the prefix state and all outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         kb_result    <= 7'd0;
         digit_count  <= 2'd0;
         locked       <= 1'b0;
         answer_ready <= 1'b0;
         reject       <= 1'b0;
      end else begin
         state        <= state_nx;
         kb_result    <= result_nx;
         digit_count  <= count_nx;
         locked       <= locked_nx;
         answer_ready <= ready_nx;
         reject       <= reject_nx;
      end
   end

endmodule

// File: doc/kb_answer_entry.md
Name: kb_answer_entry

Overview:
- Keyboard-side producer of the player's typed answer for the arithmetic game.
- Consumes decoded PS/2 set-2 scan-code bytes and accumulates decimal digits into a 7-bit value, kb_result.
- Handles backspace; on Enter, presents kb_result with a one-cycle answer_ready strobe to the answer-checking logic.
- Cleared and re-armed by new_ques at the start of each question.

Parameters:
- MAX_DIGITS, 3, maximum number of digits accepted per answer.
- MAX_VALUE, 127, largest accepted value; must be ≤ 127.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- scan_code  input  8  PS/2 set-2 byte from the receiver; valid only when scan_valid=1.
- scan_valid  input  1  one-cycle strobe qualifying scan_code.
- new_ques  input  1  level; while high, clears entry and re-arms.
- kb_result  output  7  accumulated answer value.
- digit_count  output  2  digits currently held (0..MAX_DIGITS).
- answer_ready  output  1  one-cycle pulse when an answer is committed.
- locked  output  1  high from commit until new_ques.
- reject  output  1  one-cycle pulse when a digit is refused.

Behaviour:
- Clock and reset: one clock, clock. reset_n is asynchronous, active-low.
- Reset values: kb_result=0, digit_count=0, answer_ready=0, locked=0, reject=0, FSM=IDLE.
- Latency: all outputs registered; they reflect a byte one cycle after its scan_valid cycle.
- Digit codes, main row: 45,16,1E,26,25,2E,36,3D,3E,46 → digits 0..9.
- Digit codes, keypad: 70,69,72,7A,6B,73,74,6C,75,7D → digits 0..9.
- Control codes:
  - Enter: 5A, or E0 5A.
  - Backspace: 66.
  - Break prefix: F0.
  - Extended prefix: E0.
- All other codes are ignored.
- FSM states:
  - IDLE: F0 → BREAK; E0 → EXT; a make code is acted on and stays in IDLE.
  - BREAK: next valid byte is discarded → IDLE.
  - EXT: F0 → BREAK; 5A → Enter action, then IDLE; any other byte is ignored → IDLE.
- Digit d (in IDLE, not locked):
  - Compute next = kb_result*10 + d in 11 bits (max 1279).
  - If digit_count == MAX_DIGITS or next > MAX_VALUE: value unchanged, reject pulses.
  - Otherwise kb_result = next[6:0] and digit_count increments.
  - Leading zeros are accepted and count as digits: 0,0,5 gives value 5 with count 3.
- Backspace (not locked):
  - If digit_count > 0: kb_result = kb_result/10 (floor) and digit_count decrements.
  - If digit_count == 0: no effect.
- Enter (not locked):
  - If digit_count > 0: answer_ready pulses once; locked=1; kb_result held.
  - If digit_count == 0: ignored, no pulse.
- While locked:
  - Digits, backspace and Enter have no effect; no reject pulse.
  - The prefix FSM still tracks F0/E0 so break codes stay aligned.
- new_ques (any cycle it is high):
  - Synchronously clears kb_result, digit_count, locked and FSM → IDLE.
  - Takes priority over a simultaneous scan_valid; that byte is dropped.
  - answer_ready and reject are forced to 0 that cycle.
- Break codes never act as keypresses: F0 16 produces no digit.
- Reset asserted mid-sequence (e.g. after E0) returns to IDLE; the next byte is treated as fresh.
- Only one scan_valid per cycle; no back-pressure.
- Expected RTL size: roughly 150–250 lines.

Test Plan:
- Reset, then 16, F0 16, 1E, F0 1E, 5A → kb_result=12, digit_count=2, one answer_ready pulse, locked=1; break bytes add no digits.
- Digits 1,2,8 → third digit rejected (128 > 127): kb_result=12, reject pulses once. Then 7 → kb_result=127, count=3. Then another digit → reject (count full).
- Keypad 69,72, then 66 → kb_result=1, count=1. Then 66 → 0, count=0. Then 66 again → no change. Then 5A → no answer_ready.
- Enter 4 then E0 5A → answer_ready, locked=1. Then digit 3 and 66 → kb_result stays 4, no reject. Then pulse new_ques → kb_result=0, locked=0, count=0.
- new_ques=1 in the same cycle as scan_valid with code 26 → digit dropped, kb_result=0. Next cycle, 26 → kb_result=3.
- Send E0, assert reset_n=0 mid-cycle then release, then 5A → treated as plain Enter (ignored, count=0). All outputs are 0 immediately on reset assertion, without waiting for a clock edge.
